// File: rtl/prediction_update.sv
// Branch predictor update stage: folds resolved outcomes into 2-bit saturating
// counters and queues the resulting table writes in an in-order pending-write FIFO.
module prediction_update #(
    parameter int INDEX_LEN  = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 resolve_valid,
    input  logic [INDEX_LEN-1:0] resolve_index,
    input  logic                 resolve_taken,
    output logic                 resolve_ready,
    output logic [INDEX_LEN-1:0] query_index,
    input  logic [INDEX_LEN+2:0] query_history,
    output logic                 wr_valid,
    output logic [INDEX_LEN-1:0] wr_index,
    output logic [1:0]           wr_counter,
    input  logic                 wr_ready,
    output logic                 hist_stall,
    output logic                 mispredict,
    output logic [15:0]          mispredict_count,
    output logic [15:0]          miss_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] STALL_C = CNT_W'(FIFO_DEPTH - 1);

    // query_history layout is {valid, index, counter}; all-zero means no entry
    typedef struct packed {
        logic                 valid;
        logic [INDEX_LEN-1:0] index;
        logic [1:0]           counter;
    } history_entry_t;

    typedef struct packed {
        logic [INDEX_LEN-1:0] index;
        logic [1:0]           counter;
    } wr_entry_t;

    history_entry_t hist;
    wr_entry_t      mem [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic       full;
    logic       accept;
    logic       pop;
    logic       hit;
    logic [1:0] base;
    logic [1:0] new_counter;
    logic       mispredicted;

    assign hist        = history_entry_t'(query_history);
    assign query_index = resolve_index;

    assign full          = (count == DEPTH_C);
    assign wr_valid      = (count != '0);
    assign pop           = wr_valid && wr_ready;
    assign resolve_ready = !full || pop;
    assign accept        = resolve_valid && resolve_ready;

    // Head is gated so the write port reads zero whenever nothing is pending
    assign wr_index   = wr_valid ? mem[rd_ptr].index   : '0;
    assign wr_counter = wr_valid ? mem[rd_ptr].counter : '0;

    assign hit  = hist.valid && (hist.index == resolve_index);
    assign base = hit ? hist.counter : 2'b01;

    always_comb begin
        new_counter = base;
        if (resolve_taken) begin
            if (base != 2'b11) new_counter = base + 2'd1;
        end else begin
            if (base != 2'b00) new_counter = base - 2'd1;
        end
    end

    assign mispredicted = (base[1] != resolve_taken);

    always_comb begin
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= '{index: resolve_index, counter: new_counter};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            hist_stall <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_next;
            // Based on next occupancy so the stall lines up with the fill level
            hist_stall <= (count_next >= STALL_C);
            mispredict <= accept && mispredicted;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredict_count <= '0;
            miss_count       <= '0;
        end else begin
            if (accept && mispredicted && (mispredict_count != 16'hFFFF)) begin
                mispredict_count <= mispredict_count + 16'd1;
            end
            if (accept && !hit && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_prediction_update.sv
// Directed self-checking bench for prediction_update.
module tb_prediction_update;

    localparam int IL = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          resolve_valid;
    logic [IL-1:0] resolve_index;
    logic          resolve_taken;
    logic          resolve_ready;
    logic [IL-1:0] query_index;
    logic [IL+2:0] query_history;
    logic          wr_valid;
    logic [IL-1:0] wr_index;
    logic [1:0]    wr_counter;
    logic          wr_ready;
    logic          hist_stall;
    logic          mispredict;
    logic [15:0]   mispredict_count;
    logic [15:0]   miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    prediction_update #(.INDEX_LEN(IL), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .resolve_valid    (resolve_valid),
        .resolve_index    (resolve_index),
        .resolve_taken    (resolve_taken),
        .resolve_ready    (resolve_ready),
        .query_index      (query_index),
        .query_history    (query_history),
        .wr_valid         (wr_valid),
        .wr_index         (wr_index),
        .wr_counter       (wr_counter),
        .wr_ready         (wr_ready),
        .hist_stall       (hist_stall),
        .mispredict       (mispredict),
        .mispredict_count (mispredict_count),
        .miss_count       (miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [IL+2:0] hent(input logic v, input int idx, input int ctr);
        return {v, IL'(idx), 2'(ctr)};
    endfunction

    task automatic drive(input logic v, input int idx, input logic t, input logic [IL+2:0] h);
        resolve_valid = v;
        resolve_index = IL'(idx);
        resolve_taken = t;
        query_history = h;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wr_ready = 1'b0;
        drive(1'b0, 3, 1'b0, '0);
        @(negedge clk);
        #1;
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wr_valid got %0h exp 0", wr_valid); end
        n_checks++; if (wr_index !== '0) begin n_fail++; $display("FAIL rst_wr_index got %0h exp 0", wr_index); end
        n_checks++; if (wr_counter !== 2'd0) begin n_fail++; $display("FAIL rst_wr_counter got %0h exp 0", wr_counter); end
        n_checks++; if (hist_stall !== 1'b0) begin n_fail++; $display("FAIL rst_hist_stall got %0h exp 0", hist_stall); end
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL rst_mispredict got %0h exp 0", mispredict); end
        n_checks++; if (mispredict_count !== 16'd0) begin n_fail++; $display("FAIL rst_mp_count got %0h exp 0", mispredict_count); end
        n_checks++; if (miss_count !== 16'd0) begin n_fail++; $display("FAIL rst_miss_count got %0h exp 0", miss_count); end
        n_checks++; if (resolve_ready !== 1'b1) begin n_fail++; $display("FAIL rst_resolve_ready got %0h exp 1", resolve_ready); end
        n_checks++; if (query_index !== IL'(3)) begin n_fail++; $display("FAIL rst_query_index got %0h exp 3", query_index); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Accept driven straight after reset release: uses the very first edge
    task automatic test_hit_taken;
        wr_ready = 1'b1;
        drive(1'b1, 5, 1'b1, hent(1'b1, 5, 2));
        #1;
        n_checks++; if (query_index !== IL'(5)) begin n_fail++; $display("FAIL ht_query_index got %0h exp 5", query_index); end
        n_checks++; if (resolve_ready !== 1'b1) begin n_fail++; $display("FAIL ht_ready got %0h exp 1", resolve_ready); end
        tick;
        drive(1'b0, 0, 1'b0, '0);
        #1;
        n_checks++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL ht_wr_valid got %0h exp 1", wr_valid); end
        n_checks++; if (wr_index !== IL'(5)) begin n_fail++; $display("FAIL ht_wr_index got %0h exp 5", wr_index); end
        n_checks++; if (wr_counter !== 2'd3) begin n_fail++; $display("FAIL ht_wr_counter got %0h exp 3", wr_counter); end
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL ht_mispredict got %0h exp 0", mispredict); end
        tick;
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL ht_drained got %0h exp 0", wr_valid); end
    endtask

    task automatic test_hit_not_taken;
        drive(1'b1, 9, 1'b0, hent(1'b1, 9, 3));
        tick;
        drive(1'b1, 4, 1'b0, hent(1'b1, 4, 0));
        #1;
        n_checks++; if (wr_counter !== 2'd2) begin n_fail++; $display("FAIL hn_wr_counter got %0h exp 2", wr_counter); end
        n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL hn_mispredict got %0h exp 1", mispredict); end
        n_checks++; if (mispredict_count !== 16'd1) begin n_fail++; $display("FAIL hn_mp_count got %0h exp 1", mispredict_count); end
        tick;
        drive(1'b0, 0, 1'b0, '0);
        #1;
        n_checks++; if (wr_index !== IL'(4)) begin n_fail++; $display("FAIL hn_sat0_index got %0h exp 4", wr_index); end
        n_checks++; if (wr_counter !== 2'd0) begin n_fail++; $display("FAIL hn_sat0_counter got %0h exp 0", wr_counter); end
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL hn_pulse_end got %0h exp 0", mispredict); end
        n_checks++; if (mispredict_count !== 16'd1) begin n_fail++; $display("FAIL hn_mp_hold got %0h exp 1", mispredict_count); end
        tick;
    endtask

    task automatic test_miss;
        drive(1'b1, 7, 1'b1, '0);
        tick;
        // Valid entry for a different index is still a miss
        drive(1'b1, 7, 1'b0, hent(1'b1, 8, 3));
        #1;
        n_checks++; if (wr_counter !== 2'd2) begin n_fail++; $display("FAIL ms_wr_counter got %0h exp 2", wr_counter); end
        n_checks++; if (miss_count !== 16'd1) begin n_fail++; $display("FAIL ms_miss_count got %0h exp 1", miss_count); end
        n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL ms_mispredict got %0h exp 1", mispredict); end
        n_checks++; if (mispredict_count !== 16'd2) begin n_fail++; $display("FAIL ms_mp_count got %0h exp 2", mispredict_count); end
        tick;
        drive(1'b0, 0, 1'b0, '0);
        #1;
        n_checks++; if (wr_counter !== 2'd0) begin n_fail++; $display("FAIL ms2_wr_counter got %0h exp 0", wr_counter); end
        n_checks++; if (miss_count !== 16'd2) begin n_fail++; $display("FAIL ms2_miss_count got %0h exp 2", miss_count); end
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL ms2_mispredict got %0h exp 0", mispredict); end
        tick;
    endtask

    task automatic test_full_and_drain;
        int idx_v [5] = '{10, 11, 12, 13, 14};
        int ctr_v [5] = '{2, 1, 3, 0, 2};
        logic tk_v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int dr_idx [4] = '{11, 12, 13, 15};
        int dr_ctr [4] = '{0, 3, 0, 2};
        wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, idx_v[i], tk_v[i], hent(1'b1, idx_v[i], ctr_v[i]));
            #1;
            n_checks++; if (resolve_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_ready[%0d] got %0h exp %0h", i, resolve_ready, (i < 4)); end
            tick;
            n_checks++; if (hist_stall !== (i >= 2)) begin n_fail++; $display("FAIL fill_stall[%0d] got %0h exp %0h", i, hist_stall, (i >= 2)); end
            n_checks++; if (wr_index !== IL'(10) || wr_counter !== 2'd3) begin n_fail++; $display("FAIL fill_head[%0d] got %0h/%0h exp a/3", i, wr_index, wr_counter); end
        end
        // Full FIFO with the write port ready: push and pop on the same edge
        wr_ready = 1'b1;
        drive(1'b1, 15, 1'b1, hent(1'b1, 15, 1));
        #1;
        n_checks++; if (resolve_ready !== 1'b1) begin n_fail++; $display("FAIL full_pp_ready got %0h exp 1", resolve_ready); end
        tick;
        drive(1'b0, 0, 1'b0, '0);
        wr_ready = 1'b0;
        #1;
        n_checks++; if (resolve_ready !== 1'b0) begin n_fail++; $display("FAIL full_pp_still_full got %0h exp 0", resolve_ready); end
        n_checks++; if (hist_stall !== 1'b1) begin n_fail++; $display("FAIL full_pp_stall got %0h exp 1", hist_stall); end
        wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (wr_valid !== 1'b1 || wr_index !== IL'(dr_idx[k]) || wr_counter !== 2'(dr_ctr[k])) begin
                n_fail++; $display("FAIL drain[%0d] got v%0h %0h/%0h exp v1 %0h/%0h", k, wr_valid, wr_index, wr_counter, dr_idx[k], dr_ctr[k]);
            end
            tick;
            n_checks++; if (hist_stall !== (k == 0)) begin n_fail++; $display("FAIL drain_stall[%0d] got %0h exp %0h", k, hist_stall, (k == 0)); end
        end
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %0h exp 0", wr_valid); end
    endtask

    task automatic test_back_to_back;
        int ctr_v [3] = '{1, 2, 3};
        logic tk_v [3] = '{1'b1, 1'b0, 1'b1};
        int exp_c [3] = '{2, 1, 3};
        logic exp_m [3] = '{1'b1, 1'b1, 1'b0};
        wr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 20, tk_v[k], hent(1'b1, 20, ctr_v[k]));
            tick;
            n_checks++; if (wr_valid !== 1'b1 || wr_index !== IL'(20) || wr_counter !== 2'(exp_c[k])) begin
                n_fail++; $display("FAIL b2b[%0d] got v%0h %0h/%0h exp v1 14/%0h", k, wr_valid, wr_index, wr_counter, exp_c[k]);
            end
            n_checks++; if (mispredict !== exp_m[k]) begin n_fail++; $display("FAIL b2b_mp[%0d] got %0h exp %0h", k, mispredict, exp_m[k]); end
            n_checks++; if (hist_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall[%0d] got %0h exp 0", k, hist_stall); end
        end
        drive(1'b0, 0, 1'b0, '0);
        tick;
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %0h exp 0", wr_valid); end
    endtask

    task automatic test_reset_mid_and_saturate;
        wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 30 + k, 1'b1, '0);
            tick;
        end
        drive(1'b0, 0, 1'b0, '0);
        #1;
        n_checks++; if (wr_valid !== 1'b1 || hist_stall !== 1'b1) begin n_fail++; $display("FAIL pre_rst got v%0h s%0h exp 1/1", wr_valid, hist_stall); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr_valid got %0h exp 0", wr_valid); end
        n_checks++; if (wr_index !== '0 || wr_counter !== 2'd0) begin n_fail++; $display("FAIL mid_rst_head got %0h/%0h exp 0/0", wr_index, wr_counter); end
        n_checks++; if (hist_stall !== 1'b0 || mispredict !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags got s%0h m%0h exp 0/0", hist_stall, mispredict); end
        n_checks++; if (mispredict_count !== 16'd0 || miss_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_counts got %0h/%0h exp 0/0", mispredict_count, miss_count); end
        n_checks++; if (resolve_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %0h exp 1", resolve_ready); end
        @(negedge clk);
        reset = 1'b0;
        force dut.mispredict_count = 16'hFFFE;
        force dut.miss_count = 16'hFFFE;
        #1;
        release dut.mispredict_count;
        release dut.miss_count;
        wr_ready = 1'b1;
        drive(1'b1, 40, 1'b1, '0);
        tick;
        n_checks++; if (mispredict_count !== 16'hFFFF || miss_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %0h/%0h exp ffff/ffff", mispredict_count, miss_count); end
        drive(1'b1, 41, 1'b1, '0);
        tick;
        n_checks++; if (mispredict_count !== 16'hFFFF || miss_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %0h/%0h exp ffff/ffff", mispredict_count, miss_count); end
        n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL sat_pulse got %0h exp 1", mispredict); end
        drive(1'b0, 0, 1'b0, '0);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_hit_taken();
        test_hit_not_taken();
        test_miss();
        test_full_and_drain();
        test_back_to_back();
        test_reset_mid_and_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
